// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared constants, state encoding and clamp helper for the breakout ball
package breakout_pkg;

    localparam int SCREEN_W    = 800;
    localparam int SCREEN_H    = 600;
    localparam int BALL_SIZE   = 8;
    localparam int STEP        = 2;
    localparam int PADDLE_X_L  = 770;
    localparam int LIVES_INIT  = 3;
    localparam int MISS_FRAMES = 60;

    // Largest legal left/top coordinate so the whole box stays on screen.
    localparam int X_MAX   = SCREEN_W - BALL_SIZE;
    localparam int Y_MAX   = SCREEN_H - BALL_SIZE;
    localparam int X_SERVE = PADDLE_X_L - BALL_SIZE - 1;
    localparam int Y_RESET = SCREEN_H / 2 - BALL_SIZE / 2;

    // Per-axis direction: "dec" moves toward 0, "inc" moves away from 0.
    localparam logic DIR_DEC   = 1'b0;
    localparam logic DIR_INC   = 1'b1;
    localparam logic DIR_LEFT  = DIR_DEC;
    localparam logic DIR_RIGHT = DIR_INC;
    localparam logic DIR_UP    = DIR_DEC;
    localparam logic DIR_DOWN  = DIR_INC;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2,
        ST_OVER  = 2'd3
    } ball_state_t;

    function automatic logic [10:0] clamp_pos(input logic signed [12:0] v,
                                              input logic signed [12:0] hi);
        logic [10:0] r;
        if (v < 13'sd0) begin
            r = 11'd0;
        end else if (v > hi) begin
            r = hi[10:0];
        end else begin
            r = v[10:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/breakout_ball_axis.sv
// rtl/breakout_ball_axis.sv - one ball axis: position, direction, step, clamp and wall reflect
module breakout_ball_axis
    import breakout_pkg::*;
#(
    parameter int POS_RESET = 0,
    parameter int POS_MAX   = 0,
    parameter bit HIGH_WALL = 1'b0
) (
    input  logic        clk,        // system clock
    input  logic        reset,      // synchronous, active-high
    input  logic        load,       // serve: follow load_pos, direction forced toward 0
    input  logic [10:0] load_pos,   // serve position
    input  logic        run,        // play: hits and steps take effect
    input  logic        step,       // frame tick
    input  logic        hit_inc,    // bounce pulse that sends the ball away from 0
    input  logic        hit_dec,    // bounce pulse that sends the ball toward 0
    input  logic        force_req,  // paddle face reached; honoured only when moving away from 0 on a step
    input  logic [10:0] force_pos,  // position after a paddle bounce
    output logic [10:0] pos         // left/top coordinate
);

    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic signed [11:0] TURN_HI = 12'(POS_MAX - STEP);
    localparam logic signed [12:0] MAX_S   = 13'(POS_MAX);

    logic              dir;
    logic              dir_upd;
    logic              dir_step;
    logic signed [11:0] moved;
    logic [10:0]       pos_step;
    logic              force_now;

    // Opposing pulses in the same cycle mean two blocks were struck at once: reverse.
    always_comb begin
        dir_upd = dir;
        if (hit_inc && hit_dec) begin
            dir_upd = ~dir;
        end else if (hit_inc) begin
            dir_upd = DIR_INC;
        end else if (hit_dec) begin
            dir_upd = DIR_DEC;
        end
    end

    assign moved = $signed({1'b0, pos}) + ((dir_upd == DIR_INC) ? STEP_S : -STEP_S);

    // Wall test uses the freshly moved position and the already hit-updated direction.
    always_comb begin
        pos_step = clamp_pos({moved[11], moved}, MAX_S);
        dir_step = dir_upd;
        if ((dir_upd == DIR_DEC) && (moved <= STEP_S)) begin
            dir_step = DIR_INC;
        end else if (HIGH_WALL && (dir_upd == DIR_INC) && (moved >= TURN_HI)) begin
            dir_step = DIR_DEC;
        end
    end

    assign force_now = force_req && step && (dir_upd == DIR_INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= 11'(POS_RESET);
            dir <= DIR_DEC;
        end else if (load) begin
            pos <= load_pos;
            dir <= DIR_DEC;
        end else if (run) begin
            if (force_now) begin
                pos <= force_pos;
                dir <= DIR_DEC;
            end else if (step) begin
                pos <= pos_step;
                dir <= dir_step;
            end else begin
                dir <= dir_upd;
            end
        end
    end

endmodule

// File: rtl/breakout_ball_ctrl.sv
// rtl/breakout_ball_ctrl.sv - breakout ball FSM: serve, play, miss, game over, lives and pixel-on
module breakout_ball_ctrl
    import breakout_pkg::*;
(
    input  logic        clk,         // system clock
    input  logic        reset,       // synchronous, active-high
    input  logic        frame_tick,  // one pulse per video frame
    input  logic        launch,      // leaves SERVE
    input  logic        hit_u,       // merged column bounce pulses
    input  logic        hit_d,
    input  logic        hit_l,
    input  logic        hit_r,
    input  logic [10:0] paddle_y_t,  // paddle vertical extent
    input  logic [10:0] paddle_y_b,
    input  logic [10:0] pix_x,       // current scan pixel
    input  logic [10:0] pix_y,
    output logic [10:0] ball_x_l,    // ball bounding box
    output logic [10:0] ball_x_r,
    output logic [10:0] ball_y_t,
    output logic [10:0] ball_y_b,
    output logic        ball_on,     // scan pixel inside ball
    output logic [1:0]  lives,       // remaining lives
    output logic        serving,     // in SERVE
    output logic        game_over    // in OVER
);

    localparam logic [10:0] PAD_LO     = 11'(PADDLE_X_L - STEP);
    localparam logic [10:0] PAD_HI     = 11'(PADDLE_X_L);
    localparam logic [10:0] MISS_X     = 11'(PADDLE_X_L + STEP);
    localparam logic [10:0] PAD_BOUNCE = 11'(PADDLE_X_L - BALL_SIZE);
    localparam logic [10:0] EDGE       = 11'(BALL_SIZE - 1);
    localparam logic [5:0]  MISS_LAST  = 6'(MISS_FRAMES - 1);
    localparam logic signed [12:0] HALF_BALL = 13'(BALL_SIZE / 2);
    localparam logic signed [12:0] Y_MAX_S   = 13'(Y_MAX);

    ball_state_t        state;
    logic [5:0]         miss_cnt;
    logic               miss_now;
    logic               paddle_zone;
    logic               axis_run;
    logic               axis_load;
    logic signed [12:0] pad_top;
    logic signed [12:0] pad_half;
    logic signed [12:0] serve_raw;
    logic [10:0]        serve_y;

    // Serve height centres the ball on the paddle; 13 bits keeps odd paddle inputs from wrapping.
    assign pad_top   = $signed({2'b00, paddle_y_t});
    assign pad_half  = ($signed({2'b00, paddle_y_b}) - pad_top) / 13'sd2;
    assign serve_raw = pad_top + pad_half - HALF_BALL;
    assign serve_y   = clamp_pos(serve_raw, Y_MAX_S);

    assign ball_x_r = ball_x_l + EDGE;
    assign ball_y_b = ball_y_t + EDGE;

    assign paddle_zone = (ball_x_r >= PAD_LO) && (ball_x_r <= PAD_HI) &&
                         (ball_y_b >= paddle_y_t) && (ball_y_t <= paddle_y_b);

    // A detected miss freezes the ball in the cycle it is seen.
    assign miss_now  = (state == ST_PLAY) && (ball_x_r > MISS_X);
    assign axis_run  = (state == ST_PLAY) && !miss_now;
    assign axis_load = (state == ST_SERVE);

    breakout_ball_axis #(
        .POS_RESET (X_SERVE),
        .POS_MAX   (X_MAX),
        .HIGH_WALL (1'b0)
    ) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .load      (axis_load),
        .load_pos  (11'(X_SERVE)),
        .run       (axis_run),
        .step      (frame_tick),
        .hit_inc   (hit_r),
        .hit_dec   (hit_l),
        .force_req (paddle_zone),
        .force_pos (PAD_BOUNCE),
        .pos       (ball_x_l)
    );

    breakout_ball_axis #(
        .POS_RESET (Y_RESET),
        .POS_MAX   (Y_MAX),
        .HIGH_WALL (1'b1)
    ) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .load      (axis_load),
        .load_pos  (serve_y),
        .run       (axis_run),
        .step      (frame_tick),
        .hit_inc   (hit_d),
        .hit_dec   (hit_u),
        .force_req (1'b0),
        .force_pos (11'd0),
        .pos       (ball_y_t)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SERVE;
            lives     <= 2'(LIVES_INIT);
            miss_cnt  <= 6'd0;
            serving   <= 1'b1;
            game_over <= 1'b0;
        end else begin
            case (state)
                ST_SERVE: begin
                    if (launch) begin
                        state   <= ST_PLAY;
                        serving <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (miss_now) begin
                        state <= ST_MISS;
                        if (lives != 2'd0) begin
                            lives <= lives - 2'd1;
                        end
                    end
                end
                ST_MISS: begin
                    if (frame_tick) begin
                        if (miss_cnt == MISS_LAST) begin
                            miss_cnt <= 6'd0;
                            if (lives == 2'd0) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state   <= ST_SERVE;
                                serving <= 1'b1;
                            end
                        end else begin
                            miss_cnt <= miss_cnt + 6'd1;
                        end
                    end
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                end
            endcase
        end
    end

    assign ball_on = (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
                     (pix_y >= ball_y_t) && (pix_y <= ball_y_b);

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// tb/tb_breakout_ball_ctrl.sv - scoreboard bench for breakout_ball_ctrl
module tb_breakout_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        launch;
    logic        hit_u, hit_d, hit_l, hit_r;
    logic [10:0] paddle_y_t, paddle_y_b;
    logic [10:0] pix_x, pix_y;
    logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
    logic        ball_on;
    logic [1:0]  lives;
    logic        serving, game_over;

    always #5 clk = ~clk;

    breakout_ball_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .launch     (launch),
        .hit_u      (hit_u),
        .hit_d      (hit_d),
        .hit_l      (hit_l),
        .hit_r      (hit_r),
        .paddle_y_t (paddle_y_t),
        .paddle_y_b (paddle_y_b),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .ball_x_l   (ball_x_l),
        .ball_x_r   (ball_x_r),
        .ball_y_t   (ball_y_t),
        .ball_y_b   (ball_y_b),
        .ball_on    (ball_on),
        .lives      (lives),
        .serving    (serving),
        .game_over  (game_over)
    );

    typedef struct {
        string       name;
        logic [10:0] x_l;
        logic [10:0] y_t;
        logic [1:0]  lives;
        logic        serving;
        logic        game_over;
        logic        ball_on;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   stim_done = 1'b0;

    // Monitor: pops expectations and compares against the DUT away from the active edge.
    initial begin : monitor
        exp_t        e;
        logic [10:0] ex_r, ey_b;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ex_r = e.x_l + 11'd7;
                ey_b = e.y_t + 11'd7;
                n_checks++;
                if (ball_x_l !== e.x_l || ball_x_r !== ex_r || ball_y_t !== e.y_t ||
                    ball_y_b !== ey_b || lives !== e.lives || serving !== e.serving ||
                    game_over !== e.game_over || ball_on !== e.ball_on) begin
                    n_fail++;
                    $display("FAIL %s: got x_l=%0d x_r=%0d y_t=%0d y_b=%0d lives=%0d serving=%0b game_over=%0b ball_on=%0b; want x_l=%0d x_r=%0d y_t=%0d y_b=%0d lives=%0d serving=%0b game_over=%0b ball_on=%0b",
                             e.name, ball_x_l, ball_x_r, ball_y_t, ball_y_b, lives, serving,
                             game_over, ball_on, e.x_l, ex_r, e.y_t, ey_b, e.lives, e.serving,
                             e.game_over, e.ball_on);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete, got time=%0t want completion", $time);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input int xl, input int yt, input int lv,
                       input bit srv, input bit go, input int px, input int py, input bit on);
        exp_t e;
        pix_x = 11'(px);
        pix_y = 11'(py);
        e.name      = nm;
        e.x_l       = 11'(xl);
        e.y_t       = 11'(yt);
        e.lives     = 2'(lv);
        e.serving   = srv;
        e.game_over = go;
        e.ball_on   = on;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic set_paddle(input int t, input int b);
        paddle_y_t = 11'(t);
        paddle_y_b = 11'(b);
    endtask

    initial begin : stimulus
        reset = 1'b1; frame_tick = 1'b0; launch = 1'b0;
        hit_u = 1'b0; hit_d = 1'b0; hit_l = 1'b0; hit_r = 1'b0;
        pix_x = 11'd0; pix_y = 11'd0;
        set_paddle(250, 330);
        cyc(); cyc();
        chk("reset_state", 761, 296, 3, 1, 0, 761, 296, 1);
        reset = 1'b0;

        ticks(3);
        chk("serve_track", 761, 286, 3, 1, 0, 760, 290, 0);

        launch = 1'b1; cyc(); launch = 1'b0;
        chk("launch", 761, 286, 3, 0, 0, 768, 293, 1);

        ticks(10);
        chk("play_10_ticks", 741, 266, 3, 0, 0, 748, 273, 1);

        hit_r = 1'b1; cyc(); hit_r = 1'b0;
        ticks(1);
        chk("hit_r_turn", 743, 264, 3, 0, 0, 751, 264, 0);

        ticks(1);
        chk("hit_r_no_repeat", 745, 262, 3, 0, 0, 745, 261, 0);

        hit_l = 1'b1; cyc(); hit_l = 1'b0;
        ticks(1);
        chk("hit_l_turn", 743, 260, 3, 0, 0, 743, 260, 1);

        ticks(129);
        chk("top_wall_reach", 485, 2, 3, 0, 0, 0, 0, 0);

        ticks(1);
        chk("top_wall_reflect", 483, 4, 3, 0, 0, 490, 11, 1);

        hit_r = 1'b1; cyc(); hit_r = 1'b0;
        ticks(139);
        chk("approach_paddle", 761, 282, 3, 0, 0, 761, 289, 1);

        ticks(1);
        chk("paddle_bounce", 762, 284, 3, 0, 0, 770, 284, 0);

        ticks(1);
        chk("after_bounce", 760, 286, 3, 0, 0, 767, 293, 1);

        set_paddle(0, 12);
        hit_r = 1'b1; cyc(); hit_r = 1'b0;
        ticks(3);
        chk("past_paddle_1", 766, 292, 3, 0, 0, 773, 299, 1);
        cyc();
        chk("miss_1", 766, 292, 2, 0, 0, 773, 299, 1);

        ticks(59);
        chk("miss_hold", 766, 292, 2, 0, 0, 766, 292, 1);
        ticks(1);
        cyc();
        chk("reserve_1", 761, 2, 2, 1, 0, 761, 2, 1);

        launch = 1'b1; cyc(); launch = 1'b0;
        ticks(1);
        chk("top_clamp_0", 759, 0, 2, 0, 0, 759, 0, 1);
        ticks(1);
        chk("top_bounce_up", 757, 2, 2, 0, 0, 756, 2, 0);

        set_paddle(500, 580);
        hit_l = 1'b1; hit_r = 1'b1; cyc(); hit_l = 1'b0; hit_r = 1'b0;
        ticks(1);
        chk("hit_lr_toggle", 759, 4, 2, 0, 0, 766, 11, 1);

        ticks(4);
        chk("past_paddle_2", 767, 12, 2, 0, 0, 767, 20, 0);
        cyc();
        chk("miss_2", 767, 12, 1, 0, 0, 767, 12, 1);

        ticks(60);
        cyc();
        chk("reserve_2", 761, 536, 1, 1, 0, 761, 536, 1);

        set_paddle(596, 599);
        cyc();
        chk("serve_clamp_bottom", 761, 592, 1, 1, 0, 768, 599, 1);

        launch = 1'b1; cyc(); launch = 1'b0;
        set_paddle(0, 12);
        ticks(1);
        hit_r = 1'b1; cyc(); hit_r = 1'b0;
        ticks(4);
        chk("past_paddle_3", 767, 582, 1, 0, 0, 767, 581, 0);
        cyc();
        chk("miss_3", 767, 582, 0, 0, 0, 767, 582, 1);

        ticks(60);
        chk("game_over", 767, 582, 0, 0, 1, 767, 582, 1);

        launch = 1'b1; cyc(); launch = 1'b0;
        ticks(3);
        chk("over_frozen", 767, 582, 0, 0, 1, 767, 582, 1);

        reset = 1'b1;
        cyc();
        chk("reset_from_over", 761, 296, 3, 1, 0, 761, 296, 1);
        reset = 1'b0;
        cyc();
        chk("serve_after_reset", 761, 2, 3, 1, 0, 761, 2, 1);

        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
